// File: rtl/core_l1d_pkg.sv
// Shared definitions for the L1D request/ack protocol.
//   cop_t / size_t   : request opcode and access-size encodings
//   l1d_resp_state_t : responder FSM states
//   l1d_byte_en()    : byte-lane write enables from size and address offset
package core_l1d_pkg;

    typedef logic [2:0] cop_t;
    typedef logic [2:0] size_t;

    // cop[0] = write, cop[1] = uncacheable, cop[2] = reserved
    localparam cop_t L1D_COP_RD    = 3'b000;
    localparam cop_t L1D_COP_WR    = 3'b001;
    localparam cop_t L1D_COP_RD_NC = 3'b010;
    localparam cop_t L1D_COP_WR_NC = 3'b011;

    localparam size_t L1D_SZ_B = 3'b000;
    localparam size_t L1D_SZ_H = 3'b001;
    localparam size_t L1D_SZ_W = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } l1d_resp_state_t;

    function automatic logic [3:0] l1d_byte_en(input size_t size, input logic [1:0] ofs);
        logic [3:0] be;
        case (size)
            L1D_SZ_B: be = 4'b0001 << ofs;
            L1D_SZ_H: be = 4'b0011 << ofs;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/core_l1d_resp_sram.sv
// Single-port DEPTH x 32 word array with per-byte write enables and a
// registered read. A cycle with en=1 and we=0 is a read; any we bit set
// makes it a write and leaves rdata unchanged. Contents are not reset.
//   clk   : clock
//   en    : access enable
//   we    : byte write enables (bit n -> wdata[8n+7:8n])
//   addr  : word index
//   wdata : write data, already lane-aligned
//   rdata : read data, registered, holds between reads
module core_l1d_resp_sram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            if (we == '0) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/core_l1d_responder.sv
// Responder end of the L1D request/ack interface. Accepts one request at a
// time, waits a programmable latency (optionally plus LFSR jitter), then
// performs the SRAM access on the edge entering ACK and pulses ack for one
// cycle with rdata/err.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_val    : request valid, held stable until ack
//   req_addr   : byte address
//   req_cop    : [0] write, [1] uncacheable, [2] reserved (error if set)
//   req_size   : byte / half / word
//   req_wdata  : store data, LSB-justified
//   ack        : one-cycle completion pulse
//   ack_rdata  : aligned read word; 0 for writes and errors
//   ack_err    : misaligned, out-of-range, illegal size or reserved cop bit
module core_l1d_responder
    import core_l1d_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter bit          JITTER_EN = 1'b0,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_val,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_cop,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        ack,
    output logic [31:0] ack_rdata,
    output logic        ack_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    l1d_resp_state_t state, state_nxt;
    logic [4:0]  cnt, cnt_nxt, cnt_load;
    logic [7:0]  lfsr;
    logic        accept;
    logic        enter_ack;
    logic        rd_ok;

    logic [31:0] lat_addr, lat_wdata;
    cop_t        lat_cop;
    size_t       lat_size;

    logic [31:0] cur_addr, cur_wdata;
    cop_t        cur_cop;
    size_t       cur_size;
    logic        cur_err;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_rdata;

    logic        unused_nc;

    // With a zero load count ACK is entered on the acceptance edge itself,
    // before the latched copy exists, so the access uses the live inputs
    // in IDLE and the latched copy otherwise.
    assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign cur_cop   = (state == IDLE) ? req_cop   : lat_cop;
    assign cur_size  = (state == IDLE) ? req_size  : lat_size;
    assign unused_nc = cur_cop[1];

    assign cur_err = cur_cop[2]
                   | (cur_size > L1D_SZ_W)
                   | ((cur_size == L1D_SZ_H) && cur_addr[0])
                   | ((cur_size == L1D_SZ_W) && (cur_addr[1:0] != 2'b00))
                   | (|cur_addr[31:AW+2]);

    assign cnt_load = 5'(LATENCY - 1) + (JITTER_EN ? {3'b000, lfsr[1:0]} : 5'd0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req_val) begin
                    accept    = 1'b1;
                    cnt_nxt   = cnt_load;
                    state_nxt = (cnt_load == 5'd0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 5'd1;
                if (cnt <= 5'd1) begin
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_ack = (state != ACK) && (state_nxt == ACK);

    assign sram_en = enter_ack && !cur_err;
    assign sram_we = cur_cop[0] ? l1d_byte_en(cur_size, cur_addr[1:0]) : 4'b0000;

    // Taps 8,6,5,4: maximal-length, never reaches zero from a non-zero seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lfsr      <= LFSR_SEED;
            ack       <= 1'b0;
            ack_err   <= 1'b0;
            rd_ok     <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_cop   <= '0;
            lat_size  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ack   <= enter_ack;
            if (accept) begin
                lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_cop   <= req_cop;
                lat_size  <= req_size;
            end
            if (enter_ack) begin
                ack_err <= cur_err;
                rd_ok   <= !cur_err && !cur_cop[0];
            end
        end
    end

    // rd_ok and the SRAM read register both change only on the edge
    // entering ACK, so this stays stable between acks.
    assign ack_rdata = rd_ok ? sram_rdata : '0;

    core_l1d_resp_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (cur_addr[AW+1:2]),
        .wdata (cur_wdata << {cur_addr[1:0], 3'b000}),
        .rdata (sram_rdata)
    );

`ifndef SYNTHESIS
    req_held_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        (state == WAIT) |-> req_val);
`endif

endmodule

// File: tb/tb_core_l1d_responder.sv
module tb_core_l1d_responder;
    import core_l1d_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_val;
    logic [31:0] req_addr;
    cop_t        req_cop;
    size_t       req_size;
    logic [31:0] req_wdata;
    logic        ack;
    logic [31:0] ack_rdata;
    logic        ack_err;

    logic        j_req_val;
    logic        j_ack;
    logic [31:0] j_rdata;
    logic        j_err;

    always #5 clk = ~clk;

    core_l1d_responder #(
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .JITTER_EN (1'b0),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_val   (req_val),
        .req_addr  (req_addr),
        .req_cop   (req_cop),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .ack       (ack),
        .ack_rdata (ack_rdata),
        .ack_err   (ack_err)
    );

    core_l1d_responder #(
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .JITTER_EN (1'b1),
        .LFSR_SEED (8'hA5)
    ) dut_j (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_val   (j_req_val),
        .req_addr  (32'h0000_0000),
        .req_cop   (L1D_COP_RD),
        .req_size  (L1D_SZ_W),
        .req_wdata (32'h0000_0000),
        .ack       (j_ack),
        .ack_rdata (j_rdata),
        .ack_err   (j_err)
    );

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   passed  = 0;
    int   total   = 0;
    int   ack_cnt = 0;
    int   req_id  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Monitor: every ack pops the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (ack === 1'b1) begin
            ack_cnt++;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_ack: got ack with rdata %h, expected no ack", ack_rdata);
            end else begin
                e = sb.pop_front();
                check($sformatf("ack%0d_rdata", e.id), ack_rdata, e.rdata);
                check($sformatf("ack%0d_err", e.id), {31'b0, ack_err}, {31'b0, e.err});
            end
        end
    end

    // Called at a negedge; returns at the negedge where ack is seen (hold=1)
    // or one cycle later with req_val dropped (hold=0).
    task automatic issue(input logic [31:0] a, input cop_t c, input size_t s,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat, input bit hold);
        int k;
        bit seen;
        int id;
        id = req_id;
        req_id++;
        sb.push_back(exp_t'{32'(id), exp_rd, exp_err});
        req_val   = 1'b1;
        req_addr  = a;
        req_cop   = c;
        req_size  = s;
        req_wdata = wd;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            seen = (ack === 1'b1);
        end
        check($sformatf("req%0d_latency", id), 32'(k), 32'(exp_lat));
        if (!hold || !seen) begin
            req_val = 1'b0;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'h0BAD_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    initial begin
        int base;
        int k;
        int n;
        int jit;
        int extra;
        bit seen;

        rst_n     = 1'b0;
        req_val   = 1'b0;
        req_addr  = '0;
        req_cop   = L1D_COP_RD;
        req_size  = L1D_SZ_W;
        req_wdata = '0;
        j_req_val = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_rdata", ack_rdata, 32'h0);
        check("rst_err", {31'b0, ack_err}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word write / read
        issue(32'h10, L1D_COP_WR, L1D_SZ_W, 32'hDEADBEEF, 32'h0, 1'b0, LAT, 1'b0);
        issue(32'h10, L1D_COP_RD, L1D_SZ_W, 32'h0, 32'hDEADBEEF, 1'b0, LAT, 1'b0);
        check("rdata_hold_idle", ack_rdata, 32'hDEADBEEF);

        // Partial writes
        issue(32'h13, L1D_COP_WR, L1D_SZ_B, 32'h55, 32'h0, 1'b0, LAT, 1'b0);
        issue(32'h10, L1D_COP_RD, L1D_SZ_W, 32'h0, 32'h55ADBEEF, 1'b0, LAT, 1'b0);
        issue(32'h12, L1D_COP_WR, L1D_SZ_H, 32'h1234, 32'h0, 1'b0, LAT, 1'b0);
        issue(32'h10, L1D_COP_RD, L1D_SZ_W, 32'h0, 32'h1234BEEF, 1'b0, LAT, 1'b0);

        // Errors: no write, rdata 0, err 1
        issue(32'h22, L1D_COP_RD, L1D_SZ_W, 32'h0, 32'h0, 1'b1, LAT, 1'b0);
        issue(DEPTH*4, L1D_COP_RD, L1D_SZ_B, 32'h0, 32'h0, 1'b1, LAT, 1'b0);
        issue(32'h11, L1D_COP_WR, L1D_SZ_H, 32'hFFFF, 32'h0, 1'b1, LAT, 1'b0);
        issue(DEPTH*4 + 32'h10, L1D_COP_WR, L1D_SZ_W, 32'hFFFFFFFF, 32'h0, 1'b1, LAT, 1'b0);
        issue(32'h10, L1D_COP_WR, 3'b011, 32'hFFFFFFFF, 32'h0, 1'b1, LAT, 1'b0);
        issue(32'h10, 3'b101, L1D_SZ_W, 32'hFFFFFFFF, 32'h0, 1'b1, LAT, 1'b0);
        issue(32'h10, L1D_COP_RD, L1D_SZ_W, 32'h0, 32'h1234BEEF, 1'b0, LAT, 1'b0);

        // Back-to-back reads with req_val held high
        for (int i = 0; i < 10; i++)
            issue(32'h100 + 32'(4*i), L1D_COP_WR, L1D_SZ_W, pat(i), 32'h0, 1'b0, LAT, 1'b0);
        for (int i = 0; i < 10; i++)
            issue(32'h100 + 32'(4*i), L1D_COP_RD, L1D_SZ_W, 32'h0, pat(i), 1'b0,
                  (i == 0) ? LAT : LAT + 1, (i != 9));

        // Reset during WAIT discards the request
        req_val   = 1'b1;
        req_addr  = 32'h10;
        req_cop   = L1D_COP_RD;
        req_size  = L1D_SZ_W;
        @(negedge clk);
        rst_n   = 1'b0;
        req_val = 1'b0;
        base    = ack_cnt;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wait_no_ack", 32'(ack_cnt), 32'(base));
        check("rst_wait_rdata_cleared", ack_rdata, 32'h0);
        issue(32'h10, L1D_COP_RD, L1D_SZ_W, 32'h0, 32'h1234BEEF, 1'b0, LAT, 1'b0);

        // Uncacheable write / read
        issue(32'h40, L1D_COP_WR_NC, L1D_SZ_W, 32'hCAFEF00D, 32'h0, 1'b0, LAT, 1'b0);
        issue(32'h40, L1D_COP_RD_NC, L1D_SZ_W, 32'h0, 32'hCAFEF00D, 1'b0, LAT, 1'b0);

        // Jittered instance: ten held reads
        j_req_val = 1'b1;
        n   = 0;
        jit = 0;
        for (int r = 0; r < 10; r++) begin
            k    = 0;
            seen = 1'b0;
            while (!seen && k < 40) begin
                @(negedge clk);
                k++;
                seen = (j_ack === 1'b1);
            end
            total++;
            if (seen && ((r == 0) ? (k >= LAT && k <= LAT + 3)
                                  : (k >= LAT + 1 && k <= LAT + 4))) passed++;
            else $display("FAIL jit_spacing%0d: got %0d cycles (seen=%0b), expected %0d..%0d",
                          r, k, seen, (r == 0) ? LAT : LAT + 1, (r == 0) ? LAT + 3 : LAT + 4);
            if (!seen) break;
            n++;
            if (k > ((r == 0) ? LAT : LAT + 1)) jit++;
            check($sformatf("jit_err%0d", r), {31'b0, j_err}, 32'h0);
        end
        j_req_val = 1'b0;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (j_ack === 1'b1) extra++;
        end
        check("jit_ack_count", 32'(n), 32'd10);
        check("jit_no_extra_ack", 32'(extra), 32'd0);
        total++;
        if (jit > 0) passed++;
        else $display("FAIL jit_observed: got 0 delayed acks, expected at least 1");

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
